// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and memory-side signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  logic              grant_d;
  logic              grant_i;

  // Arbiter view
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
    input  mem_readdata, mem_busywait,
    output i_readdata, i_busywait, d_readdata, d_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    output grant_d, grant_i
  );

  // Environment view (caches plus memory model)
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
    output mem_readdata, mem_busywait,
    input  i_readdata, i_busywait, d_readdata, d_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    input  grant_d, grant_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between icache and dcache
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;

  logic req_i;
  logic req_d;
  logic completion;

  assign req_i      = bus.i_read;
  assign req_d      = bus.d_read | bus.d_write;
  // Memory busy is only meaningful while a transaction is outstanding
  assign completion = (state_q != IDLE) & ~bus.mem_busywait;

  // State register and registered memory strobes/address/data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      last_grant_q    <= GRANT_I;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Grant selection in IDLE, hold while serving, release on completion
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time gets the port
        if (req_d && (!req_i || last_grant_q == GRANT_I)) begin
          state_d         = SERVE_D;
          last_grant_d    = GRANT_D;
          mem_address_d   = bus.d_address;
          mem_writedata_d = bus.d_writedata;
          mem_write_d     = bus.d_write;
          mem_read_d      = bus.d_read & ~bus.d_write;
        end else if (req_i) begin
          state_d       = SERVE_I;
          last_grant_d  = GRANT_I;
          mem_address_d = bus.i_address;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (completion) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  assign bus.i_busywait    = req_i & ~((state_q == SERVE_I) & completion);
  assign bus.d_busywait    = req_d & ~((state_q == SERVE_D) & completion);
  assign bus.i_readdata    = bus.mem_readdata;
  assign bus.d_readdata    = bus.mem_readdata;

  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  assign bus.grant_d       = (state_q == SERVE_D);
  assign bus.grant_i       = (state_q == SERVE_I);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  localparam logic [DATA_W-1:0] RD_PAT = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [DATA_W-1:0] WR_PAT = 128'h123456789ABCDEF00FEDCBA987654321;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   busy_n = 4;
  int   mem_cnt = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: busy for busy_n cycles after the strobe appears, then one completion cycle
  assign bus.mem_busywait = (bus.mem_read | bus.mem_write) && (mem_cnt < busy_n);
  assign bus.mem_readdata = ((bus.mem_read | bus.mem_write) && !bus.mem_busywait) ? RD_PAT : '0;

  always @(posedge clk) begin
    if ((bus.mem_read | bus.mem_write) && bus.mem_busywait) mem_cnt <= mem_cnt + 1;
    else mem_cnt <= 0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit is_d, input string tag);
    int n = 0;
    while ((is_d ? bus.d_busywait : bus.i_busywait) && n < 50) begin
      tick();
      n++;
    end
    check(tag, is_d ? bus.d_busywait : bus.i_busywait, 0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.i_read      = 1'b0;
    bus.i_address   = '0;
    bus.d_read      = 1'b0;
    bus.d_write     = 1'b0;
    bus.d_address   = '0;
    bus.d_writedata = '0;

    // 1: reset state, then uncontended icache read with 4 busy cycles
    tick();
    tick();
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_address", bus.mem_address, 0);
    check("rst_mem_writedata", bus.mem_writedata, 0);
    check("rst_grant_d", bus.grant_d, 0);
    check("rst_grant_i", bus.grant_i, 0);

    busy_n = 4;
    reset = 1'b0;
    bus.i_read = 1'b1;
    bus.i_address = 28'h0000010;
    #1;
    check("t1_i_busy_req", bus.i_busywait, 1);
    check("t1_d_busy_req", bus.d_busywait, 0);
    tick();
    check("t1_mem_read", bus.mem_read, 1);
    check("t1_mem_write", bus.mem_write, 0);
    check("t1_mem_address", bus.mem_address, 28'h0000010);
    check("t1_grant_i", bus.grant_i, 1);
    for (int k = 0; k < 4; k++) begin
      check("t1_i_busy_hold", bus.i_busywait, 1);
      check("t1_d_busy_hold", bus.d_busywait, 0);
      tick();
    end
    check("t1_i_busy_done", bus.i_busywait, 0);
    check("t1_i_readdata", bus.i_readdata, RD_PAT);
    bus.i_read = 1'b0;
    tick();
    check("t1_mem_read_clr", bus.mem_read, 0);
    check("t1_addr_kept", bus.mem_address, 28'h0000010);
    check("t1_grant_i_clr", bus.grant_i, 0);

    // 2: dcache writeback with 3 busy cycles
    busy_n = 3;
    bus.d_write = 1'b1;
    bus.d_address = 28'h0000020;
    bus.d_writedata = WR_PAT;
    #1;
    check("t2_d_busy_req", bus.d_busywait, 1);
    check("t2_i_busy_req", bus.i_busywait, 0);
    tick();
    check("t2_mem_write", bus.mem_write, 1);
    check("t2_mem_read", bus.mem_read, 0);
    check("t2_mem_writedata", bus.mem_writedata, WR_PAT);
    check("t2_mem_address", bus.mem_address, 28'h0000020);
    check("t2_grant_d", bus.grant_d, 1);
    for (int k = 0; k < 3; k++) begin
      check("t2_d_busy_hold", bus.d_busywait, 1);
      tick();
    end
    check("t2_d_busy_done", bus.d_busywait, 0);
    bus.d_write = 1'b0;
    tick();
    check("t2_mem_write_clr", bus.mem_write, 0);
    check("t2_addr_kept", bus.mem_address, 28'h0000020);

    // 3: simultaneous requests after reset go to D first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_n = 2;
    bus.i_read = 1'b1;
    bus.i_address = 28'h0000030;
    bus.d_read = 1'b1;
    bus.d_address = 28'h0000040;
    #1;
    check("t3_i_busy_req", bus.i_busywait, 1);
    check("t3_d_busy_req", bus.d_busywait, 1);
    tick();
    check("t3_grant_d", bus.grant_d, 1);
    check("t3_grant_i_no", bus.grant_i, 0);
    check("t3_mem_address_d", bus.mem_address, 28'h0000040);
    check("t3_i_busy_wait", bus.i_busywait, 1);
    wait_done(1'b1, "t3_d_done");
    check("t3_d_readdata", bus.d_readdata, RD_PAT);
    bus.d_read = 1'b0;
    tick();
    check("t3_idle_gap", {bus.grant_d, bus.grant_i}, 2'b00);
    check("t3_i_busy_idle", bus.i_busywait, 1);
    tick();
    check("t3_grant_i", bus.grant_i, 1);
    check("t3_mem_address_i", bus.mem_address, 28'h0000030);
    wait_done(1'b0, "t3_i_done");
    bus.i_read = 1'b0;
    tick();

    // 4: both sides requesting continuously alternate D,I,D,I,D,I
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_n = 1;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    for (int t = 0; t < 6; t++) begin
      int n = 0;
      bit exp_d;
      exp_d = (t % 2 == 0);
      while (!(bus.grant_d | bus.grant_i) && n < 10) begin
        tick();
        n++;
      end
      check("t4_grant_d", bus.grant_d, exp_d);
      check("t4_grant_i", bus.grant_i, !exp_d);
      wait_done(exp_d, "t4_done");
      tick();
      check("t4_idle_gap", {bus.grant_d, bus.grant_i}, 2'b00);
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    tick();

    // 5: reset in the second busy cycle of SERVE_D abandons the access
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_n = 5;
    bus.d_read = 1'b1;
    bus.d_address = 28'h0000050;
    tick();
    check("t5_grant_d", bus.grant_d, 1);
    tick();
    check("t5_d_busy_2nd", bus.d_busywait, 1);
    reset = 1'b1;
    tick();
    check("t5_rst_mem_read", bus.mem_read, 0);
    check("t5_rst_mem_write", bus.mem_write, 0);
    check("t5_rst_idle", {bus.grant_d, bus.grant_i}, 2'b00);
    check("t5_rst_d_busy", bus.d_busywait, 1);
    reset = 1'b0;
    tick();
    check("t5_regrant_d", bus.grant_d, 1);
    check("t5_regrant_read", bus.mem_read, 1);
    check("t5_regrant_addr", bus.mem_address, 28'h0000050);
    wait_done(1'b1, "t5_done");
    bus.d_read = 1'b0;
    tick();

    // 6: read and write together are treated as a write
    busy_n = 2;
    bus.d_read = 1'b1;
    bus.d_write = 1'b1;
    bus.d_address = 28'h0000060;
    tick();
    check("t6_mem_write", bus.mem_write, 1);
    check("t6_mem_read", bus.mem_read, 0);
    check("t6_grant_d", bus.grant_d, 1);
    wait_done(1'b1, "t6_done");
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    tick();
    check("t6_mem_write_clr", bus.mem_write, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache and the data cache.
- Both caches issue block-level miss and writeback transactions.
- The arbiter serialises these transactions, steers data, and generates per-requester busywait. Busywait stalls the fetch stage or the EX/MEM pipeline register.
- It sits between the two cache controllers and the memory model, in the memory subsystem below the pipeline.

Parameters:
ADDR_W, 28, block address width (byte address bits [31:4])
DATA_W, 128, block width in bits (16-byte line)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
i_read  in  1  icache block read request, held until i_busywait low
i_address  in  ADDR_W  icache block address
i_readdata  out  DATA_W  block returned to icache
i_busywait  out  1  icache stall
d_read  in  1  dcache block read request
d_write  in  1  dcache block write (writeback) request
d_address  in  ADDR_W  dcache block address
d_writedata  in  DATA_W  dcache writeback block
d_readdata  out  DATA_W  block returned to dcache
d_busywait  out  1  dcache stall
mem_read  out  1  memory read strobe (registered)
mem_write  out  1  memory write strobe (registered)
mem_address  out  ADDR_W  memory block address (registered)
mem_writedata  out  DATA_W  memory write block (registered)
mem_readdata  in  DATA_W  memory read block
mem_busywait  in  1  memory busy; low in completion cycle
grant_d  out  1  state==SERVE_D (debug/perf)
grant_i  out  1  state==SERVE_I (debug/perf)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled only at the rising edge of clk.
- Reset values: state=IDLE, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, last_grant=I.
  - Reset mid-transaction abandons the memory access; no completion is delivered.
- Memory contract: memory raises mem_busywait in the same cycle it sees mem_read/mem_write. It drops mem_busywait in the completion cycle with mem_readdata valid.
- Completion condition: completion = (state!=IDLE) & !mem_busywait.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Let req_i=i_read and req_d=d_read|d_write.
  - Only req_d: go to SERVE_D. Only req_i: go to SERVE_I.
  - Both: grant the side opposite last_grant (round robin). The first tie after reset goes to D.
  - Transitioning edge: register mem_address/mem_writedata from the winner; mem_read=winner read; mem_write=d_write (D only).
  - If d_read and d_write are both set, the request is treated as a write.
  - last_grant is updated to the winner.
- SERVE_x:
  - Hold all mem_* outputs stable.
  - On completion, go to IDLE, clear mem_read/mem_write, and keep mem_address.
- Per-requester outputs, combinational:
  - x_busywait = req_x & !(state==SERVE_x & completion). Busywait therefore rises in the same cycle a request appears, including while the other side is being served.
  - x_readdata = mem_readdata (pass-through, valid only in the completion cycle).
- Latency (uncontended): request seen at edge N → mem strobe from edge N+1 → busywait low in the completion cycle → requester drops the request at the next edge, which also returns the arbiter to IDLE. Minimum one IDLE cycle between grants.
- A request deasserted while not granted is simply forgotten. A request must not be deasserted while granted; this is a protocol violation and the behaviour is undefined.
- Starvation: with both sides continuously requesting, grants strictly alternate D, I, D, I.
- mem_busywait is ignored in IDLE.

Test Plan:
1. Reset high 2 cycles, then i_read=1, i_address=0x0000010; memory returns 0xAAAA…A after 4 busy cycles → mem_read=1 from next edge; i_busywait high until the completion cycle; i_readdata=0xAAAA…A in that cycle; d_busywait=0 throughout.
2. d_write=1, d_address=0x0000020, d_writedata=0x1234…; memory 3 busy cycles → mem_write=1, mem_read=0, mem_writedata=0x1234…; d_busywait drops in the completion cycle; mem_write=0 after the next edge.
3. i_read and d_read asserted in the same cycle after reset → SERVE_D first (grant_d=1); i_busywait stays 1; after D completes and 1 IDLE cycle, SERVE_I is granted.
4. Both sides requesting continuously for 6 transactions → grant sequence D,I,D,I,D,I; no back-to-back grants to the same side.
5. Reset asserted in the 2nd busy cycle of SERVE_D → next edge mem_read=mem_write=0 and state IDLE; with d_read still held, SERVE_D is re-granted the edge after reset is released.
6. d_read=1 and d_write=1 together → mem_write=1, mem_read=0 (write wins).
